// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and the iteration counter sizing helper.
package seq_signed_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DZ   = 2'd3
    } state_t;

    // Counter must hold WIDTH itself (the preparation step) down to 0.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/busy/done handshake and operand/result bus of the signed divider.
interface seq_signed_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_signed_divider_step.sv
// One restoring division step on unsigned magnitudes: shift {rem,q} left by one,
// trial-subtract the divisor, keep the difference if it is non-negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);
    // rem_in < dvs <= 2^(WIDTH-1), so the shifted remainder fits WIDTH bits
    // and bit WIDTH of the WIDTH+1-bit trial is a reliable sign.
    logic [WIDTH:0] trial;

    assign trial   = {rem_in, q_in[WIDTH-1]} - {1'b0, dvs};
    assign rem_out = trial[WIDTH] ? {rem_in[WIDTH-2:0], q_in[WIDTH-1]} : trial[WIDTH-1:0];
    assign q_out   = {q_in[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider, one restoring step per clock. Optional build macro
// DIV_OVF_SATURATE_EN saturates the -2^(WIDTH-1) / -1 quotient instead of wrapping.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_signed_divider_if.slave  bus
);
    localparam int             CW       = cnt_bits(WIDTH);
    localparam logic [CW-1:0]  CNT_PREP = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef DIV_OVF_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] abs_n;
    logic [WIDTH-1:0] abs_d;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_q;
    logic             n_neg;
    logic             q_neg;
    logic             ovf_case;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .q_in    (q),
        .dvs     (abs_d),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    // NOTE: every register here is assigned with <= so all updates in a cycle
    // see the pre-edge values; blocking = would let later lines read new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            abs_n           <= '0;
            abs_d           <= '0;
            rem             <= '0;
            q               <= '0;
            n_neg           <= 1'b0;
            q_neg           <= 1'b0;
            ovf_case        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        abs_n    <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                        abs_d    <= bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
                        n_neg    <= bus.dividend[WIDTH-1];
                        q_neg    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        ovf_case <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                        cnt      <= CNT_PREP;
                        bus.busy <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    // The first CALC cycle seeds the shift register and screens D==0.
                    if (cnt == CNT_PREP) begin
                        rem <= '0;
                        q   <= abs_n;
                        cnt <= CNT_PREP - CW'(1);
                        if (abs_d == '0) state <= S_DZ;
                    end else begin
                        rem <= step_rem;
                        q   <= step_q;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) state <= S_FIX;
                    end
                end
                S_FIX: begin
`ifdef DIV_OVF_SATURATE_EN
                    bus.quotient <= ovf_case ? MAX_VAL : (q_neg ? -q : q);
`else
                    bus.quotient <= q_neg ? -q : q;
`endif
                    bus.remainder   <= n_neg ? -rem : rem;
                    bus.div_by_zero <= 1'b0;
                    bus.overflow    <= ovf_case;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= S_IDLE;
                end
                S_DZ: begin
                    bus.quotient    <= '1;
                    bus.remainder   <= n_neg ? -abs_n : abs_n;
                    bus.div_by_zero <= 1'b1;
                    bus.overflow    <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed corner cases, handshake
// and reset scenarios, then a random signed sweep against an arithmetic model.
module tb_seq_signed_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_signed_divider_if #(.WIDTH(W)) bus ();

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    task automatic model(input logic [W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic edz, output logic eov);
        int ni;
        int di;
        ni  = $signed(n);
        di  = $signed(d);
        edz = 1'b0;
        eov = 1'b0;
        if (di == 0) begin
            eq  = '1;
            er  = n;
            edz = 1'b1;
        end else if (ni == -(2 ** (W - 1)) && di == -1) begin
            eov = 1'b1;
            er  = '0;
`ifdef DIV_OVF_SATURATE_EN
            eq  = W'(2 ** (W - 1) - 1);
`else
            eq  = W'(2 ** (W - 1));
`endif
        end else begin
            eq = W'(ni / di);
            er = W'(ni % di);
        end
    endtask

    task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] d);
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] n, input logic [W-1:0] d);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        logic         eov;
        model(n, d, eq, er, edz, eov);
        check({tag, "_q"},    {24'd0, bus.quotient},  {24'd0, eq});
        check({tag, "_r"},    {24'd0, bus.remainder}, {24'd0, er});
        check({tag, "_dz"},   {31'd0, bus.div_by_zero}, {31'd0, edz});
        check({tag, "_ovf"},  {31'd0, bus.overflow},  {31'd0, eov});
        check({tag, "_busy"}, {31'd0, bus.busy},      32'd0);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] n, input logic [W-1:0] d);
        int lat;
        int bc;
        int exp_lat;
        exp_lat = (d == '0) ? 2 : W + 2;
        start_op(n, d);
        wait_done(tag, lat, bc);
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_bcnt"}, bc,  exp_lat);
        check_result(tag, n, d);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_q"},    {24'd0, bus.quotient}, 32'd0);
        check({tag, "_r"},    {24'd0, bus.remainder}, 32'd0);
        check({tag, "_dz"},   {31'd0, bus.div_by_zero}, 32'd0);
        check({tag, "_ovf"},  {31'd0, bus.overflow}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        int seen;
        logic [W-1:0] rn;
        logic [W-1:0] rd;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("t1_100_7",   8'd100, 8'd7);
        do_op("t2_m100_7",  8'h9C,  8'd7);
        do_op("t2_100_m7",  8'd100, 8'hF9);
        do_op("t2_m100_m7", 8'h9C,  8'hF9);
        do_op("t3_55_0",    8'd55,  8'd0);
        do_op("t3_9_3",     8'd9,   8'd3);
        do_op("t4_min_m1",  8'h80,  8'hFF);
        do_op("t4_min_1",   8'h80,  8'h01);
        do_op("t4_m1_0",    8'hFF,  8'd0);

        // start pulsed while busy must be ignored
        start_op(8'd100, 8'd7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        start_op(8'd3, 8'd1);
        wait_done("t5_ign", lat, bc);
        check("t5_ign_lat", lat, W + 2 - 4);
        check_result("t5_ign", 8'd100, 8'd7);
        // start during the done cycle is accepted
        start_op(8'hCE, 8'd6);
        wait_done("t5_b2b", lat, bc);
        check("t5_b2b_lat", lat, W + 2);
        check_result("t5_b2b", 8'hCE, 8'd6);
        @(posedge clk); #1;

        // reset mid-CALC aborts the operation
        start_op(8'd77, 8'd5);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        check("t6_nodone", seen, 0);
        do_op("t6_after", 8'hB3, 8'd5);

        for (int i = 0; i < 60; i++) begin
            rn = W'($urandom);
            rd = W'($urandom);
            if (i % 10 == 0) rd = '0;
            if (i % 10 == 5) begin
                rn = 8'h80;
                rd = 8'hFF;
            end
            do_op("rnd", rn, rd);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
